// File: rtl/axil_mem_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to memory-port bridge.
package axil_mem_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    BRESP,
    RD,
    RWAIT,
    RRESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry holding register; accepts a beat whenever empty and releases it on clear.
module axil_hold_reg #(
  parameter int unsigned G_WIDTH = 32
) (
  input  logic               s_aclk,
  input  logic               s_areset,
  input  logic               in_valid,
  input  logic [G_WIDTH-1:0] in_data,
  input  logic               clear,
  output logic               full,
  output logic [G_WIDTH-1:0] data
);

  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
      data <= in_data;
    end
  end

endmodule

// File: rtl/axil_mem_bridge.sv
// AXI4-Lite slave bridging to the RAM register-side memory port, one transaction at a time.
// Optional: define AXIL_MEM_BRIDGE_DECERR_EN to answer out-of-range addresses with SLVERR.
module axil_mem_bridge
  import axil_mem_bridge_pkg::*;
#(
  parameter int unsigned G_AXI_DATAWIDTH = 32,
  parameter int unsigned G_AXI_ADDRWIDTH = 32,
  parameter int unsigned G_ADDRWIDTH     = 10,
  parameter int unsigned G_WSTRB         = G_AXI_DATAWIDTH / 8
) (
  input  logic                       s_aclk,
  input  logic                       s_areset,
  input  logic [G_AXI_ADDRWIDTH-1:0] s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [G_AXI_DATAWIDTH-1:0] s_axi_wdata,
  input  logic [G_WSTRB-1:0]         s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [G_AXI_ADDRWIDTH-1:0] s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [G_AXI_DATAWIDTH-1:0] s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic                       m_rd,
  output logic [G_ADDRWIDTH-1:0]     m_raddr,
  input  logic [G_AXI_DATAWIDTH-1:0] m_rdata,
  input  logic                       m_rvalid,
  output logic                       m_wr,
  output logic [G_ADDRWIDTH-1:0]     m_waddr,
  output logic [G_AXI_DATAWIDTH-1:0] m_wdata,
  output logic [G_WSTRB-1:0]         m_wstrb
);

  localparam int unsigned WHOLD_W = G_AXI_DATAWIDTH + G_WSTRB;

  logic                       aw_full, w_full, ar_full;
  logic [G_AXI_ADDRWIDTH-1:0] aw_addr, ar_addr;
  logic [G_AXI_DATAWIDTH-1:0] w_data;
  logic [G_WSTRB-1:0]         w_strb;
  logic                       wr_clr, rd_clr;
  logic                       aw_err, ar_err;

  state_t                     state_q, state_d;
  logic                       wr_prio_q, wr_prio_d;
  logic                       m_wr_d, m_rd_d;
  logic [G_ADDRWIDTH-1:0]     m_waddr_d, m_raddr_d;
  logic [G_AXI_DATAWIDTH-1:0] m_wdata_d, rdata_d;
  logic [G_WSTRB-1:0]         m_wstrb_d;
  logic                       bvalid_d, rvalid_d;
  logic [1:0]                 bresp_d, rresp_d;
  logic                       wr_pend, rd_pend, grant_wr;

  axil_hold_reg #(.G_WIDTH(G_AXI_ADDRWIDTH)) u_aw_hold (
    .s_aclk(s_aclk), .s_areset(s_areset), .in_valid(s_axi_awvalid), .in_data(s_axi_awaddr),
    .clear(wr_clr), .full(aw_full), .data(aw_addr)
  );

  axil_hold_reg #(.G_WIDTH(WHOLD_W)) u_w_hold (
    .s_aclk(s_aclk), .s_areset(s_areset), .in_valid(s_axi_wvalid), .in_data({s_axi_wstrb, s_axi_wdata}),
    .clear(wr_clr), .full(w_full), .data({w_strb, w_data})
  );

  axil_hold_reg #(.G_WIDTH(G_AXI_ADDRWIDTH)) u_ar_hold (
    .s_aclk(s_aclk), .s_areset(s_areset), .in_valid(s_axi_arvalid), .in_data(s_axi_araddr),
    .clear(rd_clr), .full(ar_full), .data(ar_addr)
  );

  assign s_axi_awready = ~aw_full;
  assign s_axi_wready  = ~w_full;
  assign s_axi_arready = ~ar_full;

`ifdef AXIL_MEM_BRIDGE_DECERR_EN
  assign aw_err = |aw_addr[G_AXI_ADDRWIDTH-1:G_ADDRWIDTH];
  assign ar_err = |ar_addr[G_AXI_ADDRWIDTH-1:G_ADDRWIDTH];
`else
  // Upper address bits alias away silently in this build.
  logic addr_hi_unused;
  assign addr_hi_unused = ^{aw_addr[G_AXI_ADDRWIDTH-1:G_ADDRWIDTH], ar_addr[G_AXI_ADDRWIDTH-1:G_ADDRWIDTH]};
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  assign wr_pend  = aw_full && w_full;
  assign rd_pend  = ar_full;
  assign grant_wr = wr_pend && (!rd_pend || wr_prio_q);

  // Next state, hold release and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    wr_prio_d = wr_prio_q;
    wr_clr    = 1'b0;
    rd_clr    = 1'b0;
    m_wr_d    = 1'b0;
    m_rd_d    = 1'b0;
    m_waddr_d = m_waddr;
    m_wdata_d = m_wdata;
    m_wstrb_d = m_wstrb;
    m_raddr_d = m_raddr;
    bvalid_d  = s_axi_bvalid;
    bresp_d   = s_axi_bresp;
    rvalid_d  = s_axi_rvalid;
    rresp_d   = s_axi_rresp;
    rdata_d   = s_axi_rdata;
    case (state_q)
      IDLE: begin
        if (wr_pend && rd_pend) wr_prio_d = ~grant_wr;
        if (grant_wr) begin
          if (aw_err) begin
            wr_clr   = 1'b1;
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
            state_d  = BRESP;
          end else begin
            m_wr_d    = 1'b1;
            m_waddr_d = aw_addr[G_ADDRWIDTH-1:0];
            m_wdata_d = w_data;
            m_wstrb_d = w_strb;
            state_d   = WR;
          end
        end else if (rd_pend) begin
          if (ar_err) begin
            rd_clr   = 1'b1;
            rvalid_d = 1'b1;
            rresp_d  = RESP_SLVERR;
            rdata_d  = '0;
            state_d  = RRESP;
          end else begin
            m_rd_d    = 1'b1;
            m_raddr_d = ar_addr[G_ADDRWIDTH-1:0];
            state_d   = RD;
          end
        end
      end
      WR: begin
        wr_clr   = 1'b1;
        bvalid_d = 1'b1;
        bresp_d  = RESP_OKAY;
        state_d  = BRESP;
      end
      BRESP: begin
        if (s_axi_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD: begin
        rd_clr  = 1'b1;
        state_d = RWAIT;
      end
      RWAIT: begin
        if (m_rvalid) begin
          rdata_d  = m_rdata;
          rvalid_d = 1'b1;
          rresp_d  = RESP_OKAY;
          state_d  = RRESP;
        end
      end
      RRESP: begin
        if (s_axi_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      state_q      <= IDLE;
      wr_prio_q    <= 1'b1;
      m_wr         <= 1'b0;
      m_rd         <= 1'b0;
      m_waddr      <= '0;
      m_wdata      <= '0;
      m_wstrb      <= '0;
      m_raddr      <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_rdata  <= '0;
    end else begin
      state_q      <= state_d;
      wr_prio_q    <= wr_prio_d;
      m_wr         <= m_wr_d;
      m_rd         <= m_rd_d;
      m_waddr      <= m_waddr_d;
      m_wdata      <= m_wdata_d;
      m_wstrb      <= m_wstrb_d;
      m_raddr      <= m_raddr_d;
      s_axi_bvalid <= bvalid_d;
      s_axi_bresp  <= bresp_d;
      s_axi_rvalid <= rvalid_d;
      s_axi_rresp  <= rresp_d;
      s_axi_rdata  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axil_mem_bridge.sv
// Scoreboard bench for axil_mem_bridge with a behavioural RAM on the memory port.
module tb_axil_mem_bridge;
  import axil_mem_bridge_pkg::*;

  typedef struct packed {
    logic        is_wr;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } st_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_t;

  logic        s_aclk;
  logic        s_areset;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready;
  logic        m_rd;
  logic [9:0]  m_raddr;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_wr;
  logic [9:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;

  logic [31:0] mem [0:255];

  st_t        st_q[$];
  logic [1:0] b_q[$];
  r_t         r_q[$];
  st_t        mon_e;
  logic [1:0] mon_b;
  r_t         mon_r;

  int n_checks = 0;
  int n_fail   = 0;

  axil_mem_bridge dut (
    .s_aclk(s_aclk), .s_areset(s_areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_rd(m_rd), .m_raddr(m_raddr), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .m_wr(m_wr), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb)
  );

  initial s_aclk = 1'b0;
  always #5 s_aclk = ~s_aclk;

  // RAM register side: read data one cycle after m_rd, byte-strobed writes.
  always @(posedge s_aclk) begin
    if (s_areset) m_rvalid <= 1'b0;
    else          m_rvalid <= m_rd;
    if (m_rd) m_rdata <= mem[m_raddr[9:2]];
    if (m_wr)
      for (int b = 0; b < 4; b++)
        if (m_wstrb[b]) mem[m_waddr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every strobe and response handshake against the queues.
  always @(negedge s_aclk) begin
    if (!s_areset) begin
      if (m_wr && m_rd) check("strobe_overlap", 32'(1), 32'(0));
      if (m_wr || m_rd) begin
        if (st_q.size() == 0) check("unexpected_strobe", 32'(1), 32'(0));
        else begin
          mon_e = st_q.pop_front();
          check("strobe_kind_is_wr", 32'(m_wr), 32'(mon_e.is_wr));
          if (mon_e.is_wr) begin
            check("m_waddr", 32'(m_waddr), 32'(mon_e.addr));
            check("m_wdata", m_wdata, mon_e.data);
            check("m_wstrb", 32'(m_wstrb), 32'(mon_e.strb));
          end else begin
            check("m_raddr", 32'(m_raddr), 32'(mon_e.addr));
          end
        end
      end
      if (s_axi_bvalid && s_axi_bready) begin
        if (b_q.size() == 0) check("unexpected_bvalid", 32'(1), 32'(0));
        else begin
          mon_b = b_q.pop_front();
          check("bresp", 32'(s_axi_bresp), 32'(mon_b));
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (r_q.size() == 0) check("unexpected_rvalid", 32'(1), 32'(0));
        else begin
          mon_r = r_q.pop_front();
          check("rdata", s_axi_rdata, mon_r.data);
          check("rresp", 32'(s_axi_rresp), 32'(mon_r.resp));
        end
      end
    end
  end

  task automatic push_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    st_q.push_back('{is_wr: 1'b1, addr: a, data: d, strb: s});
  endtask

  task automatic push_rd(input logic [9:0] a);
    st_q.push_back('{is_wr: 1'b0, addr: a, data: 32'h0, strb: 4'h0});
  endtask

  task automatic push_r(input logic [31:0] d, input logic [1:0] resp);
    r_q.push_back('{data: d, resp: resp});
  endtask

  task automatic send_aw(input logic [31:0] a);
    bit ok = 1'b0;
    @(posedge s_aclk); #1;
    s_axi_awaddr  = a;
    s_axi_awvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge s_aclk);
      if (s_axi_awready) ok = 1'b1;
    end
    if (!ok) check("aw_handshake_timeout", 32'(0), 32'(1));
    @(posedge s_aclk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 1'b0;
    @(posedge s_aclk); #1;
    s_axi_wdata  = d;
    s_axi_wstrb  = s;
    s_axi_wvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge s_aclk);
      if (s_axi_wready) ok = 1'b1;
    end
    if (!ok) check("w_handshake_timeout", 32'(0), 32'(1));
    @(posedge s_aclk); #1;
    s_axi_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit ok = 1'b0;
    @(posedge s_aclk); #1;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge s_aclk);
      if (s_axi_arready) ok = 1'b1;
    end
    if (!ok) check("ar_handshake_timeout", 32'(0), 32'(1));
    @(posedge s_aclk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge s_aclk);
      if (st_q.size() == 0 && b_q.size() == 0 && r_q.size() == 0) ok = 1'b1;
    end
    if (!ok) check("drain_timeout", 32'(0), 32'(1));
    @(posedge s_aclk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    bit ok;
    s_areset = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0;  s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;

    // Reset state
    repeat (3) @(posedge s_aclk);
    @(negedge s_aclk);
    check("rst_awready", 32'(s_axi_awready), 32'(1));
    check("rst_wready",  32'(s_axi_wready),  32'(1));
    check("rst_arready", 32'(s_axi_arready), 32'(1));
    check("rst_bvalid",  32'(s_axi_bvalid),  32'(0));
    check("rst_rvalid",  32'(s_axi_rvalid),  32'(0));
    check("rst_m_wr",    32'(m_wr),          32'(0));
    check("rst_m_rd",    32'(m_rd),          32'(0));
    check("rst_rdata",   s_axi_rdata,        32'h0);
    @(posedge s_aclk); #1;
    s_areset = 1'b0;

    // Single write then read back
    push_wr(10'h010, 32'hDEADBEEF, 4'hF); b_q.push_back(RESP_OKAY);
    do_write(32'h010, 32'hDEADBEEF, 4'hF);
    wait_drain();
    push_rd(10'h010); push_r(32'hDEADBEEF, RESP_OKAY);
    send_ar(32'h010);
    wait_drain();

    // W first, AW five cycles later
    push_wr(10'h020, 32'h12345678, 4'hF); b_q.push_back(RESP_OKAY);
    send_w(32'h12345678, 4'hF);
    repeat (5) begin
      @(negedge s_aclk);
      check("split_no_early_m_wr", 32'(m_wr), 32'(0));
    end
    send_aw(32'h020);
    wait_drain();

    // Partial strobe merges into existing word
    push_wr(10'h020, 32'hAABBCCDD, 4'h3); b_q.push_back(RESP_OKAY);
    do_write(32'h020, 32'hAABBCCDD, 4'h3);
    wait_drain();
    push_rd(10'h020); push_r(32'h1234CCDD, RESP_OKAY);
    send_ar(32'h020);
    wait_drain();

    // Zero strobe still pulses m_wr but leaves data intact
    push_wr(10'h010, 32'hFFFFFFFF, 4'h0); b_q.push_back(RESP_OKAY);
    do_write(32'h010, 32'hFFFFFFFF, 4'h0);
    wait_drain();
    push_rd(10'h010); push_r(32'hDEADBEEF, RESP_OKAY);
    send_ar(32'h010);
    wait_drain();

    // First contention after reset: write wins
    push_wr(10'h030, 32'h11111111, 4'hF); push_rd(10'h010);
    b_q.push_back(RESP_OKAY); push_r(32'hDEADBEEF, RESP_OKAY);
    fork
      send_aw(32'h030);
      send_w(32'h11111111, 4'hF);
      send_ar(32'h010);
    join
    wait_drain();

    // Second contention: read wins
    push_rd(10'h030); push_wr(10'h040, 32'h22222222, 4'hF);
    b_q.push_back(RESP_OKAY); push_r(32'h11111111, RESP_OKAY);
    fork
      send_ar(32'h030);
      send_aw(32'h040);
      send_w(32'h22222222, 4'hF);
    join
    wait_drain();

    // R backpressure with a second AR parked in the hold
    s_axi_rready = 1'b0;
    push_rd(10'h030); push_r(32'h11111111, RESP_OKAY);
    send_ar(32'h030);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge s_aclk);
      if (s_axi_rvalid) ok = 1'b1;
    end
    check("bp_rvalid_seen", 32'(ok), 32'(1));
    check("bp_arready_hold_empty", 32'(s_axi_arready), 32'(1));
    push_rd(10'h040); push_r(32'h22222222, RESP_OKAY);
    send_ar(32'h040);
    @(negedge s_aclk);
    check("bp_arready_hold_full", 32'(s_axi_arready), 32'(0));
    for (int i = 0; i < 10; i++) begin
      @(negedge s_aclk);
      check("bp_rvalid_stable", 32'(s_axi_rvalid), 32'(1));
      check("bp_rdata_stable", s_axi_rdata, 32'h11111111);
    end
    @(posedge s_aclk); #1;
    s_axi_rready = 1'b1;
    wait_drain();

    // Reset while waiting for RAM read data
    push_rd(10'h010);
    send_ar(32'h010);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge s_aclk);
      if (m_rd) ok = 1'b1;
    end
    check("rst_mid_m_rd_seen", 32'(ok), 32'(1));
    @(posedge s_aclk); #1;
    s_areset = 1'b1;
    @(posedge s_aclk);
    @(negedge s_aclk);
    check("rst_mid_rvalid",  32'(s_axi_rvalid),  32'(0));
    check("rst_mid_bvalid",  32'(s_axi_bvalid),  32'(0));
    check("rst_mid_awready", 32'(s_axi_awready), 32'(1));
    check("rst_mid_wready",  32'(s_axi_wready),  32'(1));
    check("rst_mid_arready", 32'(s_axi_arready), 32'(1));
    check("rst_mid_m_rd",    32'(m_rd),          32'(0));
    check("rst_mid_m_wr",    32'(m_wr),          32'(0));
    @(posedge s_aclk); #1;
    s_areset = 1'b0;

    // Address beyond the memory window
`ifdef AXIL_MEM_BRIDGE_DECERR_EN
    b_q.push_back(RESP_SLVERR);
    do_write(32'h400, 32'h55AA55AA, 4'hF);
    wait_drain();
    push_r(32'h0, RESP_SLVERR);
    send_ar(32'h400);
    wait_drain();
`else
    push_wr(10'h000, 32'h55AA55AA, 4'hF); b_q.push_back(RESP_OKAY);
    do_write(32'h400, 32'h55AA55AA, 4'hF);
    wait_drain();
    push_rd(10'h000); push_r(32'h55AA55AA, RESP_OKAY);
    send_ar(32'h400);
    wait_drain();
`endif

    repeat (5) @(posedge s_aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
